// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: one-stage registered branch/jump resolver.
// Evaluates the branch condition, computes the resolved next PC and link
// value, flags mispredictions against the fetch predictor, and keeps
// saturating retire/mispredict counters. Results sit in an output register
// behind a valid/ready handshake so fetch can stall the stage.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_funct3,
   input  logic             i_is_jal,
   input  logic             i_is_jalr,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_imm,
   input  logic [XLEN-1:0]  i_rs1_rdata,
   input  logic [XLEN-1:0]  i_rs2_rdata,
   input  logic             i_pred_taken,
   input  logic [XLEN-1:0]  i_pred_target,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_take,
   output logic [XLEN-1:0]  o_next_pc,
   output logic [XLEN-1:0]  o_link,
   output logic             o_mispredict,
   output logic             o_illegal,
   output logic [CNT_W-1:0] o_br_count,
   output logic [CNT_W-1:0] o_mp_count
);

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
   localparam logic [XLEN-1:0] BIT0_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   logic            accept, retire;
   logic            cond, bad_f3, jump;
   logic            take_d, illegal_d, mp_d;
   logic [XLEN-1:0] link_d, br_tgt, jalr_tgt, target_d, next_pc_d, pred_pc_d;

   // The output register can take a new result when empty or draining.
   assign o_ready = !o_valid || i_ready;
   assign accept  = i_valid && o_ready && !i_flush;
   // A result retiring in a flush cycle is not counted.
   assign retire  = o_valid && i_ready && !i_flush;

   // Resolve condition, target and misprediction from the incoming operands.
   always_comb begin
      cond   = 1'b0;
      bad_f3 = 1'b0;
      case (i_funct3)
         BR_BEQ:  cond = (i_rs1_rdata == i_rs2_rdata);
         BR_BNE:  cond = (i_rs1_rdata != i_rs2_rdata);
         BR_BLT:  cond = ($signed(i_rs1_rdata) <  $signed(i_rs2_rdata));
         BR_BGE:  cond = ($signed(i_rs1_rdata) >= $signed(i_rs2_rdata));
         BR_BLTU: cond = (i_rs1_rdata <  i_rs2_rdata);
         BR_BGEU: cond = (i_rs1_rdata >= i_rs2_rdata);
         default: bad_f3 = 1'b1;
      endcase

      jump      = i_is_jal || i_is_jalr;
      illegal_d = !jump && bad_f3;
      // An illegal encoding has cond=0, so it resolves as not-taken.
      take_d    = jump || cond;

      link_d    = i_pc + PC_STEP;
      br_tgt    = i_pc + i_imm;
      jalr_tgt  = (i_rs1_rdata + i_imm) & BIT0_MASK;
      // JAL wins when both jump flags are set.
      target_d  = (i_is_jalr && !i_is_jal) ? jalr_tgt : br_tgt;
      next_pc_d = take_d ? target_d : link_d;

      pred_pc_d = i_pred_taken ? i_pred_target : link_d;
      mp_d      = (next_pc_d != pred_pc_d);
   end

   // Output result register with handshake; flush beats accept and retire.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid      <= 1'b0;
         o_take       <= 1'b0;
         o_next_pc    <= '0;
         o_link       <= '0;
         o_mispredict <= 1'b0;
         o_illegal    <= 1'b0;
      end else begin
         if (i_flush)     o_valid <= 1'b0;
         else if (accept) o_valid <= 1'b1;
         else if (retire) o_valid <= 1'b0;

         if (accept) begin
            o_take       <= take_d;
            o_next_pc    <= next_pc_d;
            o_link       <= link_d;
            o_mispredict <= mp_d;
            o_illegal    <= illegal_d;
         end
      end
   end

   // Saturating performance counters, bumped when a legal result retires.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_br_count <= '0;
         o_mp_count <= '0;
      end else if (retire && !o_illegal) begin
         if (o_br_count != '1)
            o_br_count <= o_br_count + CNT_W'(1);
         if (o_mispredict && (o_mp_count != '1))
            o_mp_count <= o_mp_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: table of single transactions,
// then backpressure, flush, counter saturation and async reset sequences.
module tb_branch_resolve_unit;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_valid;
   logic             o_ready;
   logic [2:0]       i_funct3;
   logic             i_is_jal, i_is_jalr;
   logic [XLEN-1:0]  i_pc, i_imm, i_rs1_rdata, i_rs2_rdata;
   logic             i_pred_taken;
   logic [XLEN-1:0]  i_pred_target;
   logic             i_flush;
   logic             o_valid;
   logic             i_ready;
   logic             o_take;
   logic [XLEN-1:0]  o_next_pc, o_link;
   logic             o_mispredict, o_illegal;
   logic [CNT_W-1:0] o_br_count, o_mp_count;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_funct3(i_funct3), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
      .i_pc(i_pc), .i_imm(i_imm), .i_rs1_rdata(i_rs1_rdata),
      .i_rs2_rdata(i_rs2_rdata), .i_pred_taken(i_pred_taken),
      .i_pred_target(i_pred_target), .i_flush(i_flush), .o_valid(o_valid),
      .i_ready(i_ready), .o_take(o_take), .o_next_pc(o_next_pc),
      .o_link(o_link), .o_mispredict(o_mispredict), .o_illegal(o_illegal),
      .o_br_count(o_br_count), .o_mp_count(o_mp_count)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [2:0]  f3;
      logic        jal, jalr;
      logic [31:0] pc, imm, rs1, rs2;
      logic        pt;
      logic [31:0] ptg;
      logic        e_take;
      logic [31:0] e_np, e_link;
      logic        e_mp, e_ill;
   } vec_t;

   vec_t tbl[13];
   vec_t sv;
   int   n_chk = 0;
   int   n_miss = 0;
   int   exp_br = 0;
   int   exp_mp = 0;

   function automatic vec_t mk(logic [2:0] f3, logic jal, logic jalr,
                               logic [31:0] pc, logic [31:0] imm,
                               logic [31:0] rs1, logic [31:0] rs2,
                               logic pt, logic [31:0] ptg, logic e_take,
                               logic [31:0] e_np, logic [31:0] e_link,
                               logic e_mp, logic e_ill);
      vec_t v;
      v.f3 = f3; v.jal = jal; v.jalr = jalr; v.pc = pc; v.imm = imm;
      v.rs1 = rs1; v.rs2 = rs2; v.pt = pt; v.ptg = ptg; v.e_take = e_take;
      v.e_np = e_np; v.e_link = e_link; v.e_mp = e_mp; v.e_ill = e_ill;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v, logic vld);
      i_valid       = vld;
      i_funct3      = v.f3;
      i_is_jal      = v.jal;
      i_is_jalr     = v.jalr;
      i_pc          = v.pc;
      i_imm         = v.imm;
      i_rs1_rdata   = v.rs1;
      i_rs2_rdata   = v.rs2;
      i_pred_taken  = v.pt;
      i_pred_target = v.ptg;
   endtask

   // Bench-side counter model, saturating at the 4-bit maximum.
   task automatic model_retire(vec_t v);
      if (!v.e_ill) begin
         if (exp_br < CMAX) exp_br++;
         if (v.e_mp && exp_mp < CMAX) exp_mp++;
      end
   endtask

   task automatic chk_result(string nm, vec_t v);
      chk({nm, ".valid"},   32'(o_valid),      32'd1);
      chk({nm, ".take"},    32'(o_take),       32'(v.e_take));
      chk({nm, ".next_pc"}, o_next_pc,         v.e_np);
      chk({nm, ".link"},    o_link,            v.e_link);
      chk({nm, ".mp"},      32'(o_mispredict), 32'(v.e_mp));
      chk({nm, ".ill"},     32'(o_illegal),    32'(v.e_ill));
   endtask

   task automatic chk_counts(string nm);
      chk({nm, ".br_count"}, 32'(o_br_count), 32'(exp_br));
      chk({nm, ".mp_count"}, 32'(o_mp_count), 32'(exp_mp));
   endtask

   initial begin
      //             f3     jal  jalr pc            imm           rs1           rs2           pt   ptg           take np            link          mp   ill
      tbl[0]  = mk(3'b000, 1'b0, 1'b0, 32'h100,      32'h20,       32'h5,        32'h5,        1'b1, 32'h120,      1'b1, 32'h120,      32'h104,      1'b0, 1'b0);
      tbl[1]  = mk(3'b100, 1'b0, 1'b0, 32'h100,      32'h20,       32'hFFFFFFFF, 32'h1,        1'b1, 32'h120,      1'b1, 32'h120,      32'h104,      1'b0, 1'b0);
      tbl[2]  = mk(3'b110, 1'b0, 1'b0, 32'h100,      32'h20,       32'hFFFFFFFF, 32'h1,        1'b1, 32'h120,      1'b0, 32'h104,      32'h104,      1'b1, 1'b0);
      tbl[3]  = mk(3'b000, 1'b0, 1'b1, 32'h200,      32'h4,        32'h1003,     32'h0,        1'b0, 32'h0,        1'b1, 32'h1006,     32'h204,      1'b1, 1'b0);
      tbl[4]  = mk(3'b000, 1'b1, 1'b0, 32'h200,      32'hFFFFFFF0, 32'h0,        32'h0,        1'b1, 32'h1F0,      1'b1, 32'h1F0,      32'h204,      1'b0, 1'b0);
      tbl[5]  = mk(3'b001, 1'b0, 1'b0, 32'h300,      32'h40,       32'h3,        32'h3,        1'b0, 32'h0,        1'b0, 32'h304,      32'h304,      1'b0, 1'b0);
      tbl[6]  = mk(3'b101, 1'b0, 1'b0, 32'h400,      32'h10,       32'h1,        32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 32'h410,      32'h404,      1'b1, 1'b0);
      tbl[7]  = mk(3'b111, 1'b0, 1'b0, 32'h400,      32'h10,       32'h1,        32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 32'h404,      32'h404,      1'b0, 1'b0);
      tbl[8]  = mk(3'b010, 1'b0, 1'b0, 32'h500,      32'h8,        32'h7,        32'h7,        1'b1, 32'h508,      1'b0, 32'h504,      32'h504,      1'b1, 1'b1);
      tbl[9]  = mk(3'b000, 1'b1, 1'b1, 32'h600,      32'h100,      32'h5000,     32'h0,        1'b1, 32'h700,      1'b1, 32'h700,      32'h604,      1'b0, 1'b0);
      tbl[10] = mk(3'b011, 1'b0, 1'b1, 32'h0,        32'h0,        32'h10,       32'h0,        1'b0, 32'h0,        1'b1, 32'h10,       32'h4,        1'b1, 1'b0);
      tbl[11] = mk(3'b000, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h20,       32'h9,        32'h9,        1'b1, 32'h10,       1'b1, 32'h10,       32'hFFFFFFF4, 1'b0, 1'b0);
      tbl[12] = mk(3'b000, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h0,        1'b1, 1'b0);
      // Saturation stimulus: taken BEQ predicted not-taken.
      sv = mk(3'b000, 1'b0, 1'b0, 32'h100, 32'h20, 32'h1, 32'h1, 1'b0, 32'h0,
              1'b1, 32'h120, 32'h104, 1'b1, 1'b0);

      i_rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
      drive(tbl[0], 1'b0);
      repeat (2) @(negedge i_clk);
      chk("rst.ready", 32'(o_ready), 32'd1);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst.valid",   32'(o_valid),   32'd0);
      chk("rst.next_pc", o_next_pc,      32'd0);
      chk("rst.ready2",  32'(o_ready),   32'd1);
      chk_counts("rst");

      // Table: one transaction at a time, check result, then retire.
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i], 1'b1);
         @(negedge i_clk);
         chk_result($sformatf("v%0d", i), tbl[i]);
         chk_counts($sformatf("v%0d.pre", i));
         i_valid = 1'b0;
         @(negedge i_clk);
         model_retire(tbl[i]);
         chk($sformatf("v%0d.drain", i), 32'(o_valid), 32'd0);
         chk_counts($sformatf("v%0d.post", i));
      end

      // Backpressure: hold A for 3 cycles with B waiting, then stream B, C.
      drive(tbl[0], 1'b1);
      @(negedge i_clk);
      chk_result("bp.A", tbl[0]);
      i_ready = 1'b0;
      drive(tbl[6], 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         chk($sformatf("bp.hold%0d.ready", k), 32'(o_ready), 32'd0);
         chk_result($sformatf("bp.hold%0d", k), tbl[0]);
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      model_retire(tbl[0]);
      chk_result("bp.B", tbl[6]);
      chk_counts("bp.B");
      drive(tbl[9], 1'b1);
      @(negedge i_clk);
      model_retire(tbl[6]);
      chk_result("bp.C", tbl[9]);
      chk_counts("bp.C");
      i_valid = 1'b0;
      @(negedge i_clk);
      model_retire(tbl[9]);
      chk("bp.drain", 32'(o_valid), 32'd0);
      chk_counts("bp.end");

      // Flush with a result pending, downstream ready and a new input.
      drive(tbl[3], 1'b1);
      @(negedge i_clk);
      chk_result("fl.pre", tbl[3]);
      drive(tbl[1], 1'b1);
      i_flush = 1'b1;
      @(negedge i_clk);
      chk("fl.valid", 32'(o_valid), 32'd0);
      chk_counts("fl");
      i_flush = 1'b0;
      i_valid = 1'b0;
      @(negedge i_clk);
      chk("fl.discard", 32'(o_valid), 32'd0);
      chk_counts("fl.after");

      // Fresh reset, then 17 back-to-back mispredicting legal branches.
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      exp_br = 0; exp_mp = 0;
      drive(sv, 1'b1);
      repeat (17) @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      chk("sat.br_count", 32'(o_br_count), 32'd15);
      chk("sat.mp_count", 32'(o_mp_count), 32'd15);

      // Asynchronous reset mid-stream, away from any clock edge.
      drive(sv, 1'b1);
      i_ready = 1'b0;
      @(negedge i_clk);
      chk("ar.pre_valid", 32'(o_valid), 32'd1);
      #2;
      i_rst = 1'b1;
      #1;
      chk("ar.valid",    32'(o_valid),      32'd0);
      chk("ar.take",     32'(o_take),       32'd0);
      chk("ar.next_pc",  o_next_pc,         32'd0);
      chk("ar.link",     o_link,            32'd0);
      chk("ar.mp",       32'(o_mispredict), 32'd0);
      chk("ar.ill",      32'(o_illegal),    32'd0);
      chk("ar.br_count", 32'(o_br_count),   32'd0);
      chk("ar.mp_count", 32'(o_mp_count),   32'd0);
      chk("ar.ready",    32'(o_ready),      32'd1);
      i_valid = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Registered, handshaked branch/jump resolution stage placed between decode/operand-read and the fetch redirect path. It covers:
- conditional branch evaluation (BEQ/BNE/BLT/BGE/BLTU/BGEU);
- JAL/JALR next-PC computation;
- a misprediction check against the fetch predictor;
- saturating performance counters.

Results are held in an output register with a valid/ready handshake, so the fetch unit can stall it.

Parameters:
XLEN, 32, operand/PC width in bits
CNT_W, 32, width of each performance counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_valid  in  1  input transaction valid
o_ready  out  1  unit can accept an input this cycle
i_funct3  in  3  branch condition code (riscv_pkg Br* encodings)
i_is_jal  in  1  transaction is JAL (overrides funct3)
i_is_jalr  in  1  transaction is JALR (overrides funct3; JAL wins if both are set)
i_pc  in  XLEN  PC of the instruction
i_imm  in  XLEN  sign-extended offset
i_rs1_rdata  in  XLEN  rs1 operand
i_rs2_rdata  in  XLEN  rs2 operand
i_pred_taken  in  1  fetch predicted taken
i_pred_target  in  XLEN  fetch predicted target
i_flush  in  1  pipeline flush
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_take  out  1  control transfer taken
o_next_pc  out  XLEN  resolved next PC
o_link  out  XLEN  i_pc+4, the rd write value for JAL/JALR
o_mispredict  out  1  resolved next PC differs from predicted next PC
o_illegal  out  1  funct3 is 010/011 on a non-jump
o_br_count  out  CNT_W  count of retired legal transactions
o_mp_count  out  CNT_W  count of retired mispredicts

Behaviour:
- Reset (async, i_rst=1): o_valid=0, o_take=0, o_next_pc=0, o_link=0, o_mispredict=0, o_illegal=0, both counters=0. While in reset, o_ready=1 combinationally.
- o_ready = !o_valid || i_ready. This is combinational and does not depend on i_valid.
- Accept = i_valid && o_ready && !i_flush.
  - On accept, all result registers load and o_valid=1 next cycle.
  - Latency is exactly 1 cycle; sustained throughput is 1 per cycle while i_ready=1.
- Hold: if o_valid && !i_ready, all outputs stay stable until the handshake completes.
- Retire = o_valid && i_ready. If retire occurs with no accept, o_valid=0 next cycle.
- Flush: i_flush=1 clears o_valid next cycle and discards any input presented that cycle. Counters do not increment for a result retiring in the flush cycle. Flush has priority over accept and retire.
- Condition evaluation, for non-jumps:
  - BEQ: equal. BNE: not equal.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - 010/011: take=0, illegal=1.
- Jumps: JAL and JALR always take=1.
- Target, all arithmetic modulo 2^XLEN with wrap and no overflow flag:
  - branch/JAL target = pc+imm;
  - JALR target = (rs1+imm) with bit0 cleared.
- o_next_pc = take ? target : pc+4.
- o_link = pc+4 for every transaction.
- Misprediction:
  - predicted next PC = pred_taken ? pred_target : pc+4;
  - o_mispredict = (o_next_pc != predicted next PC);
  - an illegal transaction evaluates as not-taken for this check.
- Counters:
  - on retire without flush, o_br_count += 1 if !o_illegal;
  - o_mp_count += 1 if o_mispredict && !o_illegal;
  - both saturate at 2^CNT_W-1 and never wrap.
- i_funct3 is ignored when i_is_jal or i_is_jalr is set.

Test Plan:
1. Reset, then BEQ with rs1=rs2=0x5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> one cycle later o_valid=1, take=1, next_pc=0x120, mispredict=0; after retire br_count=1, mp_count=0.
2. BLT with rs1=0xFFFFFFFF, rs2=0x1 -> take=1. BLTU with the same operands -> take=0, next_pc=pc+4; pred_taken=1 gives mispredict=1 and mp_count increments.
3. JALR with rs1=0x1003, imm=0x4, pc=0x200 -> next_pc=0x1006, link=0x204, take=1. Same pc with JAL, imm=0xFFFFFFF0 -> next_pc=0x1F0.
4. Backpressure: hold i_ready=0 for 3 cycles with o_valid=1 -> o_ready=0 and outputs stable. A new i_valid is not accepted until i_ready=1, then the stream proceeds back-to-back at 1/cycle.
5. Flush while o_valid=1, i_ready=1 and i_valid=1 -> next cycle o_valid=0 and counters unchanged. funct3=010 non-jump -> illegal=1, take=0, br_count unchanged.
6. With CNT_W=4: retire 17 mispredicting legal branches -> both counters saturate at 15. Assert i_rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
